queue: RTL and testbench
========================

Name: queue

Overview:
- Synchronous circular byte queue with indexed load, tail push and head pop.
- Continuously presents its two oldest entries as one 16-bit word (`top_conc`).
- Used as an operand buffer feeding a downstream 16-bit consumer; controlled by a 2-bit opcode each clock.

Parameters:
- WIDTH, 8, entry width in bits; `top_conc` is 2*WIDTH.
- DEPTH, 8, number of entries; power of two.
- PW, $clog2(DEPTH) = 3, width of `pos_back` and of the internal pointers.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- back  in  WIDTH  data for load/push.
- pos_back  in  PW  index relative to head for load (opcode 00).
- opcode  in  2  00 LOAD, 01 NOP, 10 PUSH, 11 POP.
- top_conc  out  2*WIDTH  {entry[head], entry[head+1]}.
- count  out  PW+1  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async, rst=1):
  - head=0, tail=0, count=0.
  - All storage cleared to 0.
  - top_conc=0, empty=1, full=0.
  - Reset asserted mid-operation aborts the current operation immediately; no partial write survives.
- Storage: DEPTH x WIDTH registers, circular; slot addresses are taken mod DEPTH (wrap-around).
- LOAD (00):
  - if pos_back < count: overwrite slot head+pos_back with back; count unchanged.
  - if pos_back == count and !full: write slot head+pos_back, count+1, tail+1 (append).
  - if pos_back > count, or full with pos_back == count: ignored, no state change.
- NOP (01): no state change.
- PUSH (10):
  - if !full: slot tail <= back, tail+1, count+1.
  - if full: ignored.
- POP (11):
  - if !empty: head+1, count-1; the popped slot's contents are not cleared.
  - if empty: ignored.
- Only one operation per cycle (opcode is an encoding), so there are no simultaneous push/pop cases.
- Output timing:
  - top_conc, count, empty and full are combinational from registered state.
  - Each updates in the same cycle after the clock edge, i.e. one-edge latency from the opcode.
- top_conc masking:
  - upper byte = entry[head] if count>=1, else 0.
  - lower byte = entry[head+1] if count>=2, else 0.
- Pointers wrap from DEPTH-1 to 0.
- count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: QUEUE_ERR_EN.
- When defined:
  - Adds output `err` (1 bit), a sticky flag.
  - err is set on any ignored operation: push when full, pop when empty, LOAD with invalid pos_back.
  - Cleared only by rst.
- When undefined: no `err` port, no extra logic; ignored operations are silent.

Decomposition:
- queue_pkg:
  - opcode localparams/enum: OP_LOAD=2'b00, OP_NOP=2'b01, OP_PUSH=2'b10, OP_POP=2'b11.
  - Default WIDTH/DEPTH constants.
- Sub-module queue_regfile:
  - DEPTH x WIDTH register array.
  - One write port (addr, data, we), two combinational read ports, async clear.
- Top level `queue` holds pointers, count, opcode decode and output masking.

Test Plan:
- Reset, then no ops -> top_conc=16'h0000, count=0, empty=1.
- LOAD back=1,2,3,4 with pos_back=0,1,2,3 on four edges -> count=4, top_conc=16'h0102.
- Then POP -> count=3, top_conc=16'h0203. Then PUSH back=200 -> count=4, top_conc=16'h0203, slot 4 holds 8'hC8.
- PUSH 8 values into an empty queue, then PUSH 9th -> full=1, 9th ignored. Pop 8 -> empty=1; head/tail wrapped to 0. Extra POP is ignored; err=1 when QUEUE_ERR_EN is defined.
- With count=2, LOAD pos_back=5 -> ignored. LOAD pos_back=1 back=8'hAA -> top_conc lower byte=8'hAA.
- Assert rst asynchronously between clock edges while count=3 -> outputs clear immediately, before the next edge.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared definitions for the circular byte queue: opcode encoding and default geometry.
// Imported by queue and queue_regfile.
package queue_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_NOP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b11
    } opcode_e;

    localparam int QUEUE_WIDTH = 8;
    localparam int QUEUE_DEPTH = 8;

endpackage

// File: rtl/queue_regfile.sv
// DEPTH x WIDTH register array for the queue: one write port, two combinational
// read ports, asynchronous clear.
module queue_regfile
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/queue.sv
// Circular byte queue with indexed load, tail push and head pop; presents the two
// oldest entries as one word. Define QUEUE_ERR_EN to add the sticky `err` output.
module queue
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   back,
    input  logic [PW-1:0]      pos_back,
    input  logic [1:0]         opcode,
    output logic [2*WIDTH-1:0] top_conc,
    output logic [PW:0]        count,
    output logic               empty,
    output logic               full
`ifdef QUEUE_ERR_EN
    ,
    output logic               err
`endif
);

    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    head, tail;
    logic [PW:0]      cnt;
    logic [PW-1:0]    head_nxt, tail_nxt;
    logic [PW:0]      cnt_nxt;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [PW:0]      pos_ext;
    logic             ignored;
    logic [WIDTH-1:0] rd_head, rd_next;

    assign pos_ext = {1'b0, pos_back};
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign count   = cnt;

    // Opcode decode: at most one state change per cycle.
    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        cnt_nxt  = cnt;
        we       = 1'b0;
        waddr    = tail;
        ignored  = 1'b0;
        case (opcode_e'(opcode))
            OP_LOAD: begin
                waddr = head + pos_back;
                if (pos_ext < cnt) begin
                    we = 1'b1;
                end else if (pos_ext == cnt && !full) begin
                    // Loading one past the last entry appends.
                    we       = 1'b1;
                    tail_nxt = tail + PTR_ONE;
                    cnt_nxt  = cnt + CNT_ONE;
                end else begin
                    ignored = 1'b1;
                end
            end
            OP_PUSH: begin
                if (!full) begin
                    we       = 1'b1;
                    tail_nxt = tail + PTR_ONE;
                    cnt_nxt  = cnt + CNT_ONE;
                end else begin
                    ignored = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    head_nxt = head + PTR_ONE;
                    cnt_nxt  = cnt - CNT_ONE;
                end else begin
                    ignored = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
        end
    end

    queue_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (back),
        .raddr_a (head),
        .raddr_b (head + PTR_ONE),
        .rdata_a (rd_head),
        .rdata_b (rd_next)
    );

    // Stale slots beyond the valid entries never reach the consumer.
    assign top_conc = {(cnt != '0)    ? rd_head : '0,
                       (cnt > CNT_ONE) ? rd_next : '0};

`ifdef QUEUE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (ignored) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_ignored;
    assign unused_ignored = ignored;
`endif

endmodule

// File: tb/tb_queue.sv
// Directed bench for queue: load/push/pop sequences, full/empty boundaries,
// invalid loads and asynchronous reset.
module tb_queue;
    import queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  back = '0;
    logic [2:0]  pos_back = '0;
    logic [1:0]  opcode = OP_NOP;
    logic [15:0] top_conc;
    logic [3:0]  count;
    logic        empty, full;
`ifdef QUEUE_ERR_EN
    logic        err;
`endif

    int tests = 0;
    int failures = 0;

    queue dut (
        .clk      (clk),
        .rst      (rst),
        .back     (back),
        .pos_back (pos_back),
        .opcode   (opcode),
        .top_conc (top_conc),
        .count    (count),
        .empty    (empty),
        .full     (full)
`ifdef QUEUE_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] b, input logic [2:0] p);
        @(negedge clk);
        opcode   = o;
        back     = b;
        pos_back = p;
        @(posedge clk);
        #1;
        opcode = OP_NOP;
    endtask

    task automatic check_state(input string tag, input logic [15:0] t, input logic [3:0] c,
                               input logic e, input logic f);
        check({tag, ".top"},   32'(top_conc), 32'(t));
        check({tag, ".count"}, 32'(count),    32'(c));
        check({tag, ".empty"}, 32'(empty),    32'(e));
        check({tag, ".full"},  32'(full),     32'(f));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 16'h0000, 4'd0, 1'b1, 1'b0);
`ifdef QUEUE_ERR_EN
        check("reset.err", 32'(err), 32'd0);
`endif

        // Indexed loads that append one at a time
        do_op(OP_LOAD, 8'd1, 3'd0);
        check_state("load0", 16'h0100, 4'd1, 1'b0, 1'b0);
        do_op(OP_LOAD, 8'd2, 3'd1);
        do_op(OP_LOAD, 8'd3, 3'd2);
        do_op(OP_LOAD, 8'd4, 3'd3);
        check_state("load4", 16'h0102, 4'd4, 1'b0, 1'b0);

        do_op(OP_POP, 8'd0, 3'd0);
        check_state("pop1", 16'h0203, 4'd3, 1'b0, 1'b0);
        do_op(OP_NOP, 8'hFF, 3'd0);
        check_state("nop", 16'h0203, 4'd3, 1'b0, 1'b0);
        do_op(OP_PUSH, 8'd200, 3'd0);
        check_state("push200", 16'h0203, 4'd4, 1'b0, 1'b0);

        // Drain to expose slot 4 at the head
        do_op(OP_POP, 8'd0, 3'd0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("pop3", 16'h04C8, 4'd2, 1'b0, 1'b0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("slot4", 16'hC800, 4'd1, 1'b0, 1'b0);

        // Fill from an empty, freshly reset queue
        pulse_reset();
        check_state("rst2", 16'h0000, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op(OP_PUSH, 8'(8'h10 + i), 3'd0);
        end
        check_state("fill8", 16'h1011, 4'd8, 1'b0, 1'b1);
        do_op(OP_PUSH, 8'h99, 3'd0);
        check_state("push9", 16'h1011, 4'd8, 1'b0, 1'b1);
`ifdef QUEUE_ERR_EN
        check("push9.err", 32'(err), 32'd1);
`endif
        do_op(OP_LOAD, 8'h5E, 3'd7);
        check_state("loadfull", 16'h1011, 4'd8, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_op(OP_POP, 8'd0, 3'd0);
        end
        check_state("pop6", 16'h165E, 4'd2, 1'b0, 1'b0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("pop7", 16'h5E00, 4'd1, 1'b0, 1'b0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("pop8", 16'h0000, 4'd0, 1'b1, 1'b0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("popempty", 16'h0000, 4'd0, 1'b1, 1'b0);

        // Head and tail both wrapped to slot 0
        do_op(OP_PUSH, 8'hAB, 3'd0);
        check_state("wrap1", 16'hAB00, 4'd1, 1'b0, 1'b0);
        do_op(OP_PUSH, 8'hAC, 3'd0);
        check_state("wrap2", 16'hABAC, 4'd2, 1'b0, 1'b0);

        do_op(OP_LOAD, 8'h55, 3'd5);
        check_state("loadbad", 16'hABAC, 4'd2, 1'b0, 1'b0);
        do_op(OP_LOAD, 8'hAA, 3'd1);
        check_state("loadovr", 16'hABAA, 4'd2, 1'b0, 1'b0);
        do_op(OP_LOAD, 8'h77, 3'd2);
        check_state("loadapp", 16'hABAA, 4'd3, 1'b0, 1'b0);
        do_op(OP_POP, 8'd0, 3'd0);
        do_op(OP_POP, 8'd0, 3'd0);
        check_state("appchk", 16'h7700, 4'd1, 1'b0, 1'b0);
        do_op(OP_PUSH, 8'h31, 3'd0);
        do_op(OP_PUSH, 8'h32, 3'd0);
        check_state("count3", 16'h7731, 4'd3, 1'b0, 1'b0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state("async", 16'h0000, 4'd0, 1'b1, 1'b0);
`ifdef QUEUE_ERR_EN
        check("async.err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        do_op(OP_PUSH, 8'h5A, 3'd0);
        do_op(OP_LOAD, 8'h00, 3'd1);
        check_state("postrst", 16'h5A00, 4'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
